writeback_block: RTL and testbench

Write-back engine for the block-RAM cache. On eviction of a dirty line, it accepts the full victim block together with its tag and index, then writes it to the byte-wide main memory one byte per cycle, lowest offset first. It sits beside the miss-fill reader on the same memory: the reader fills lines, this block drains them, using the same address and byte order.

---
 rtl/writeback_block_pkg.sv | 36 +++
 rtl/writeback_shifter.sv | 58 +++++
 rtl/writeback_block.sv | 162 ++++++++++++++++
 tb/tb_writeback_block.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_block_pkg.sv
// Shared definitions for the cache/main-memory datapath (write-back engine and
// miss-fill reader): bus widths, derived-geometry helpers and FSM state encoding.
package writeback_block_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wb_state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned log2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Width of the byte-offset field of an address.
  function automatic int unsigned offset_bits(input int unsigned block_size_byte);
    return log2_f(block_size_byte);
  endfunction

  // Width of the set-index field of an address.
  function automatic int unsigned set_bits(input int unsigned cache_size_byte,
                                           input int unsigned block_size_byte,
                                           input int unsigned way);
    return log2_f(cache_size_byte / (block_size_byte * way));
  endfunction

endpackage

// File: rtl/writeback_shifter.sv
// Byte shift register and byte counter for the write-back engine.
// Ports:
//   clk3, reset       clock, synchronous active-high reset
//   load_i            capture rest_i and clear the counter
//   shift_i           drop one byte and advance the counter
//   rest_i            victim line without its byte 0 (byte 0 is sent on accept)
//   cnt_o             offset of the byte currently on the memory bus
//   offset_next_c     offset field for the following byte
//   next_byte_c       the following byte
module writeback_shifter
  import writeback_block_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE_BYTE = 16,
  localparam int unsigned OFF_W = offset_bits(BLOCK_SIZE_BYTE),
  localparam int unsigned CNT_W = OFF_W + 1,
  localparam int unsigned REM_W = (BLOCK_SIZE_BYTE - 1) * DATA_W
) (
  input  logic              clk3,
  input  logic              reset,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [REM_W-1:0]  rest_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [OFF_W-1:0]  offset_next_c,
  output logic [DATA_W-1:0] next_byte_c
);

  logic [REM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load/shift control; the lowest remaining byte is always the next to send.
  always_comb begin
    rem_d = rem_q;
    cnt_d = cnt_q;
    if (load_i) begin
      rem_d = rest_i;
      cnt_d = '0;
    end else if (shift_i) begin
      rem_d = rem_q >> DATA_W;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk3) begin
    if (reset) begin
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o         = cnt_q;
  assign offset_next_c = OFF_W'(cnt_q + CNT_W'(1));
  assign next_byte_c   = rem_q[DATA_W-1:0];

endmodule

// File: rtl/writeback_block.sv
// Write-back engine: accepts a dirty victim line and streams it to byte-wide
// main memory, lowest offset first, one byte per cycle.
// Ports:
//   clk3, reset              clock, synchronous active-high reset
//   wb_valid / wb_ready      victim handshake (ready only while idle)
//   tag, index, block        victim line, sampled on the accept edge only
//   mem_en, mem_we           memory enable / write enable
//   mem_addr, mem_din        {tag, index, offset} and write byte
//   wb_done                  one-cycle pulse after the last byte
//   busy                     high while writing or signalling done
module writeback_block
  import writeback_block_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE_BYTE = 16,
  parameter int unsigned CACHE_SIZE_BYTE = 32 * 1024,
  parameter int unsigned WAY             = 1,
  localparam int unsigned OFF_W = offset_bits(BLOCK_SIZE_BYTE),
  localparam int unsigned IDX_W = set_bits(CACHE_SIZE_BYTE, BLOCK_SIZE_BYTE, WAY),
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W,
  localparam int unsigned BLK_W = BLOCK_SIZE_BYTE * DATA_W,
  localparam int unsigned CNT_W = OFF_W + 1
) (
  input  logic              clk3,
  input  logic              reset,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [TAG_W-1:0]  tag,
  input  logic [IDX_W-1:0]  index,
  input  logic [BLK_W-1:0]  block,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              wb_done,
  output logic              busy
);

  wb_state_e state_q, state_d;

  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              wb_done_q, wb_done_d;
  logic              wb_ready_q, wb_ready_d;
  logic              busy_q, busy_d;

  logic              load_c, shift_c, accept_c, last_c;
  logic [CNT_W-1:0]  cnt;
  logic [OFF_W-1:0]  offset_next_c;
  logic [DATA_W-1:0] next_byte_c;

  writeback_shifter #(
    .BLOCK_SIZE_BYTE(BLOCK_SIZE_BYTE)
  ) u_shifter (
    .clk3         (clk3),
    .reset        (reset),
    .load_i       (load_c),
    .shift_i      (shift_c),
    .rest_i       (block[BLK_W-1:DATA_W]),
    .cnt_o        (cnt),
    .offset_next_c(offset_next_c),
    .next_byte_c  (next_byte_c)
  );

  assign accept_c = (state_q == ST_IDLE) && wb_valid && wb_ready_q;
  // The byte at the final offset is already on the bus this cycle.
  assign last_c   = (cnt == CNT_W'(BLOCK_SIZE_BYTE - 1));

  // State register; reset wins over a simultaneous request.
  always_ff @(posedge clk3) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept_c) state_d = ST_WRITE;
      ST_WRITE: if (last_c) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    load_c     = 1'b0;
    shift_c    = 1'b0;
    tag_d      = tag_q;
    idx_d      = idx_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    wb_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          load_c     = 1'b1;
          tag_d      = tag;
          idx_d      = index;
          mem_addr_d = {tag, index, OFF_W'(0)};
          mem_din_d  = block[DATA_W-1:0];
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b1;
        end
      end
      ST_WRITE: begin
        if (!last_c) begin
          shift_c    = 1'b1;
          mem_addr_d = {tag_q, idx_q, offset_next_c};
          mem_din_d  = next_byte_c;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b1;
        end else begin
          wb_done_d = 1'b1;
        end
      end
      default: ;
    endcase
    wb_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  // Output and latched-victim registers.
  always_ff @(posedge clk3) begin
    if (reset) begin
      tag_q      <= '0;
      idx_q      <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      wb_done_q  <= 1'b0;
      wb_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      tag_q      <= tag_d;
      idx_q      <= idx_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      wb_done_q  <= wb_done_d;
      wb_ready_q <= wb_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign wb_ready = wb_ready_q;
  assign busy     = busy_q;
  assign mem_en   = mem_en_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign wb_done  = wb_done_q;

endmodule

// File: tb/tb_writeback_block.sv
// Scoreboard bench for writeback_block: a 16-byte-line instance and a 4-byte-line
// instance; expected memory writes are queued at issue and checked by a monitor.
module tb_writeback_block;

  logic clk3 = 1'b0;
  logic reset;
  always #5 clk3 = ~clk3;

  int cyc = 0;
  always @(posedge clk3) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  // 16-byte line, 32 KiB cache: tag 1, index 11, offset 4
  logic         v16, t16, rdy16, en16, mw16, done16, busy16;
  logic [10:0]  i16;
  logic [127:0] b16;
  logic [15:0]  a16;
  logic [7:0]   d16;

  // 4-byte line, 32 KiB cache: tag 1, index 13, offset 2
  logic         v4, t4, rdy4, en4, mw4, done4, busy4;
  logic [12:0]  i4;
  logic [31:0]  b4;
  logic [15:0]  a4;
  logic [7:0]   d4;

  writeback_block #(.BLOCK_SIZE_BYTE(16), .CACHE_SIZE_BYTE(32*1024), .WAY(1)) u_wb16 (
    .clk3(clk3), .reset(reset), .wb_valid(v16), .wb_ready(rdy16),
    .tag(t16), .index(i16), .block(b16),
    .mem_en(en16), .mem_we(mw16), .mem_addr(a16), .mem_din(d16),
    .wb_done(done16), .busy(busy16)
  );

  writeback_block #(.BLOCK_SIZE_BYTE(4), .CACHE_SIZE_BYTE(32*1024), .WAY(1)) u_wb4 (
    .clk3(clk3), .reset(reset), .wb_valid(v4), .wb_ready(rdy4),
    .tag(t4), .index(i4), .block(b4),
    .mem_en(en4), .mem_we(mw4), .mem_addr(a4), .mem_din(d4),
    .wb_done(done4), .busy(busy4)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  din;
    int          k;
  } wr_t;

  wr_t exp16[$];
  wr_t exp4[$];
  int  pend16 = 0, pend4 = 0;
  int  acc16 = 0, acc4 = 0;
  bit  chkr16 = 1'b0, chkr4 = 1'b0;
  logic [7:0] mem [logic [15:0]];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: memory writes and done pulses of both instances against the queues.
  always @(negedge clk3) begin
    wr_t e;
    if (mw16) begin
      if (exp16.size() == 0) chk("unexpected_write16", 128'(mw16), 128'(0));
      else begin
        e = exp16.pop_front();
        chk("addr16", 128'(a16), 128'(e.addr));
        chk("din16", 128'(d16), 128'(e.din));
        chk("wr_cycle16", 128'(cyc), 128'(acc16 + e.k));
      end
      mem[a16] = d16;
      chk("busy16_wr", 128'(busy16), 128'(1));
      chk("ready16_wr", 128'(rdy16), 128'(0));
    end
    if (en16 || mw16) chk("en_we16", 128'(en16), 128'(mw16));
    if (chkr16) begin
      chk("ready16_after_done", 128'(rdy16), 128'(1));
      chk("busy16_after_done", 128'(busy16), 128'(0));
      chkr16 = 1'b0;
    end
    if (done16) begin
      if (pend16 == 0) chk("unexpected_done16", 128'(done16), 128'(0));
      else begin
        pend16--;
        chk("done_cycle16", 128'(cyc), 128'(acc16 + 16));
        chk("done_ready16", 128'(rdy16), 128'(0));
        chkr16 = 1'b1;
      end
    end

    if (mw4) begin
      if (exp4.size() == 0) chk("unexpected_write4", 128'(mw4), 128'(0));
      else begin
        e = exp4.pop_front();
        chk("addr4", 128'(a4), 128'(e.addr));
        chk("din4", 128'(d4), 128'(e.din));
        chk("wr_cycle4", 128'(cyc), 128'(acc4 + e.k));
      end
      mem[a4] = d4;
    end
    if (en4 || mw4) chk("en_we4", 128'(en4), 128'(mw4));
    if (chkr4) begin
      chk("ready4_after_done", 128'(rdy4), 128'(1));
      chkr4 = 1'b0;
    end
    if (done4) begin
      if (pend4 == 0) chk("unexpected_done4", 128'(done4), 128'(0));
      else begin
        pend4--;
        chk("done_cycle4", 128'(cyc), 128'(acc4 + 4));
        chkr4 = 1'b1;
      end
    end
  end

  task automatic send16(input logic t, input logic [10:0] ix, input logic [127:0] b,
                        input logic [15:0] base, input int nexp, input bit with_done,
                        input bit keep, output int acc);
    bit rdy, ok;
    for (int k = 0; k < nexp; k++)
      exp16.push_back('{addr: base + 16'(k), din: b[8*k +: 8], k: k});
    if (with_done) pend16++;
    @(negedge clk3);
    v16 = 1'b1; t16 = t; i16 = ix; b16 = b;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      rdy = rdy16;
      @(posedge clk3);
      #1;
      ok = rdy;
    end
    chk("accept16", 128'(ok), 128'(1));
    acc = cyc;
    acc16 = cyc;
    if (!keep) begin
      @(negedge clk3);
      v16 = 1'b0;
    end
  endtask

  task automatic send4(input logic t, input logic [12:0] ix, input logic [31:0] b,
                       input logic [15:0] base);
    bit rdy, ok;
    for (int k = 0; k < 4; k++)
      exp4.push_back('{addr: base + 16'(k), din: b[8*k +: 8], k: k});
    pend4++;
    @(negedge clk3);
    v4 = 1'b1; t4 = t; i4 = ix; b4 = b;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      rdy = rdy4;
      @(posedge clk3);
      #1;
      ok = rdy;
    end
    chk("accept4", 128'(ok), 128'(1));
    acc4 = cyc;
    @(negedge clk3);
    v4 = 1'b0;
  endtask

  task automatic drain(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk3);
      ok = (exp16.size() == 0) && (exp4.size() == 0) && (pend16 == 0) &&
           (pend4 == 0) && rdy16 && rdy4;
    end
    chk(nm, 128'(ok), 128'(1));
  endtask

  // Read a line back from the memory image, as the miss-fill reader would.
  function automatic logic [127:0] rd_line(input logic [15:0] base, input int n);
    logic [127:0] r;
    logic [15:0]  a;
    r = '0;
    for (int k = 0; k < n; k++) begin
      a = base + 16'(k);
      if (mem.exists(a)) r[8*k +: 8] = mem[a];
      else               r[8*k +: 8] = 8'h5A;
    end
    return r;
  endfunction

  initial begin
    int a1, a2;
    logic [127:0] blk_a, blk_h, blk_r, blk_c, blk_d;
    logic [15:0]  ra;
    blk_a = 128'h0F0E0D0C0B0A09080706050403020100;
    blk_h = 128'h0123456789ABCDEFFEDCBA9876543210;
    blk_r = 128'hA5A4A3A2A1A09F9E9D9C9B9A99989796;
    blk_c = 128'h11223344556677889900AABBCCDDEEFF;
    blk_d = 128'hC3C2C1C0B3B2B1B0A3A2A1A093929190;

    // Reset together with a request: nothing may be accepted.
    reset = 1'b1;
    v16 = 1'b1; t16 = 1'b1; i16 = 11'h005; b16 = blk_a;
    v4 = 1'b1; t4 = 1'b0; i4 = 13'h0; b4 = 32'h0;
    repeat (3) @(posedge clk3);
    @(negedge clk3);
    chk("rst_ready16", 128'(rdy16), 128'(1));
    chk("rst_busy16", 128'(busy16), 128'(0));
    chk("rst_en16", 128'(en16), 128'(0));
    chk("rst_we16", 128'(mw16), 128'(0));
    chk("rst_addr16", 128'(a16), 128'(0));
    chk("rst_din16", 128'(d16), 128'(0));
    chk("rst_done16", 128'(done16), 128'(0));
    chk("rst_ready4", 128'(rdy4), 128'(1));
    chk("rst_busy4", 128'(busy4), 128'(0));
    chk("rst_addr4", 128'(a4), 128'(0));
    reset = 1'b0; v16 = 1'b0; v4 = 1'b0;
    @(negedge clk3);
    chk("no_accept_under_reset", 128'(busy16), 128'(0));

    // Basic write-back: 0x8050..0x805F with bytes 00..0F.
    send16(1'b1, 11'h005, blk_a, 16'h8050, 16, 1'b1, 1'b0, a1);
    drain("drain_basic");
    chk("roundtrip_basic", rd_line(16'h8050, 16), blk_a);

    // Inputs changed during WRITE must not affect the line in flight.
    send16(1'b0, 11'h7FF, blk_h, 16'h7FF0, 16, 1'b1, 1'b0, a1);
    t16 = 1'b1; i16 = 11'h2AA; b16 = ~blk_h;
    repeat (3) begin
      @(negedge clk3);
      b16 = b16 ^ 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A;
    end
    drain("drain_hold");
    chk("roundtrip_hold", rd_line(16'h7FF0, 16), blk_h);

    // Small line: 0xFFFC..0xFFFF with AA BB CC DD.
    send4(1'b1, 13'h1FFF, 32'hDDCCBBAA, 16'hFFFC);
    drain("drain_small");
    chk("roundtrip_small", rd_line(16'hFFFC, 4), 128'h00000000000000000000000DDCCBBAA);

    // Reset after 5 bytes: only offsets 0..4 land, no done.
    send16(1'b0, 11'h010, blk_r, 16'h0100, 5, 1'b0, 1'b0, a1);
    repeat (4) @(negedge clk3);
    reset = 1'b1;
    @(negedge clk3);
    chk("midrst_we", 128'(mw16), 128'(0));
    chk("midrst_en", 128'(en16), 128'(0));
    chk("midrst_ready", 128'(rdy16), 128'(1));
    chk("midrst_busy", 128'(busy16), 128'(0));
    chk("midrst_done", 128'(done16), 128'(0));
    chk("midrst_addr", 128'(a16), 128'(0));
    reset = 1'b0;
    repeat (20) @(negedge clk3);
    chk("midrst_queue", 128'(exp16.size()), 128'(0));
    for (int k = 0; k < 16; k++) begin
      ra = 16'h0100 + 16'(k);
      chk("midrst_written", 128'(mem.exists(ra)), 128'(k < 5));
    end
    chk("midrst_bytes", rd_line(16'h0100, 5), 128'h000000000000000000000009A99989796);

    // Back-to-back with wb_valid held: accepts exactly 18 cycles apart.
    send16(1'b1, 11'h100, blk_c, 16'h9000, 16, 1'b1, 1'b1, a1);
    send16(1'b0, 11'h101, blk_d, 16'h1010, 16, 1'b1, 1'b0, a2);
    chk("b2b_spacing", 128'(a2 - a1), 128'(18));
    drain("drain_b2b");
    chk("roundtrip_b2b_c", rd_line(16'h9000, 16), blk_c);
    chk("roundtrip_b2b_d", rd_line(16'h1010, 16), blk_d);

    repeat (5) @(negedge clk3);
    chk("queues_empty", 128'(exp16.size() + exp4.size() + pend16 + pend4), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
